fix_checksum_verify: RTL and testbench
======================================

# fix_checksum_verify

Downstream companion of the FIX checksum stage. Consumes the same received byte stream and the computed checksum. Parses the `10=ddd<SOH>` trailer, converts the three ASCII digits to binary, and compares the result against the computed value. Reports ok, mismatch, malformed-trailer or timeout once per message to the message-accept logic.

## Interface
Parameters:
- TIMEOUT, 16: cycles to wait after the trailer SOH for `calc_valid_i` before reporting a timeout.
- TO_W, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  8  received byte.
- valid_i  in  1  `data_i` is valid this cycle. Bytes are consumed only when high.
- calc_checksum_i  in  9  checksum from the checksum stage (mod 256, so bit 8 is expected 0).
- calc_valid_i  in  1  one-cycle strobe: `calc_checksum_i` is valid.
- done_o  out  1  one-cycle pulse: verdict available.
- ok_o  out  1  trailer matched. Held until the next `done_o`.
- err_o  out  2  00 ok, 01 mismatch, 10 format, 11 timeout. Held until the next `done_o`.
- rx_checksum_o  out  8  binary value of the received digits. Held until the next `done_o`.

## Operation
- FSM states: HUNT, DIGITS, TERM, WAIT_CALC, REPORT.
- HUNT: on each accepted byte, shift into a 4-byte window. A window equal to SOH,'1','0','=' (0x01,0x31,0x30,0x3D) → DIGITS. Clear acc and digit count.
- DIGITS: each accepted byte must be 0x30–0x39.
  - Valid digit: acc = acc*10 + (byte-0x30). acc is 10 bits wide, so no overflow for 3 digits.
  - Non-digit: set fmt_err, go → TERM.
  - After the third digit → TERM.
- TERM: the next accepted byte must be SOH.
  - Any other byte sets fmt_err.
  - acc > 255 sets fmt_err.
  - Then → WAIT_CALC.
- Calc latch: runs independently of the FSM.
  - Any `calc_valid_i` latches `calc_checksum_i` and sets calc_seen. Latest strobe wins.
  - calc_seen clears on entry to REPORT.
- WAIT_CALC:
  - If fmt_err → REPORT with err=10, regardless of calc.
  - Else if calc_seen, or `calc_valid_i` this cycle (the live value is used) → REPORT.
  - Else count. When the count reaches TIMEOUT → REPORT with err=11.
- REPORT: one cycle.
  - Pulse `done_o`.
  - Load `ok_o` = (err==00), `err_o`, and `rx_checksum_o` = acc[7:0].
  - Mismatch is decided as {1'b0, acc[7:0]} != calc (9-bit compare, so calc bit 8 set is always a mismatch).
  - Clear the window, fmt_err and counters, then → HUNT.
- Bytes that arrive in WAIT_CALC or REPORT are not consumed by the FSM. The next message's header cannot contain a trailer before its body.
- Gaps: `valid_i` low stalls all byte-driven transitions. The timeout counter still runs in WAIT_CALC.

## Timing
- Reset, asynchronous: state=HUNT.
  - window, acc, counters, calc_seen, fmt_err = 0.
  - `done_o`=0, `ok_o`=0, `err_o`=00, `rx_checksum_o`=0.
- Latency, calc already seen: terminating SOH accepted at cycle N → WAIT_CALC at N+1 → `done_o` at N+2.
- Latency, calc arrives later: `done_o` one cycle after the cycle where `calc_valid_i` is sampled in WAIT_CALC.
- Latency, timeout: `done_o` exactly TIMEOUT+1 cycles after entering WAIT_CALC.
- Simultaneous events:
  - `calc_valid_i` in the same cycle as the SOH accept is latched and used.
  - `calc_valid_i` during REPORT is latched for the next message, because the latch beats the clear.
- Reset mid-message: drops all partial state. No `done_o` is produced for the aborted message.

## Structure
- Shared package `fix_pkg`:
  - ASCII constants SOH, CHAR_0, CHAR_1, CHAR_9, CHAR_EQ.
  - FSM state enum.
  - `chk_err_t` enum for the `err_o` codes.
  - Reused by the checksum stage and future tag parsers.
- One sub-module: `fix_tag_match`. A 4-byte shift window with a valid-gated shift, a clear input, and a match output for a fixed 4-byte pattern given as a parameter. It will be reused for other tag detection.
- Everything else lives in this module.

## Test plan
- Trailer "10=062<SOH>" with calc 62 latched 3 cycles earlier → `done_o` 2 cycles after SOH, `ok_o`=1, `err_o`=00, `rx_checksum_o`=0x3E.
- Same trailer, calc 63 → `ok_o`=0, `err_o`=01. Calc 0x13E (bit 8 set) → `err_o`=01.
- "10=2a5<SOH>" and "10=300<SOH>" → `err_o`=10 without waiting for calc. "10=062X" → `err_o`=10.
- Valid trailer and no `calc_valid_i` → `done_o` exactly TIMEOUT+1 cycles after WAIT_CALC entry, `err_o`=11. Calc arriving 5 cycles after SOH instead → ok, `done_o` one cycle later.
- Randomized `valid_i` gaps inside "10=199<SOH>" with calc 199 → ok, `rx_checksum_o`=0xC7. A tag "210=" inside the body does not trigger.
- `rst` asserted after the second digit → outputs zero immediately. A following clean message verifies normally.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared FIX protocol definitions: ASCII constants, checksum-verify FSM states and verdict codes.
// Used by the checksum stage, the trailer verifier and tag parsers.
package fix_pkg;

  localparam logic [7:0] SOH     = 8'h01;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_1  = 8'h31;
  localparam logic [7:0] CHAR_9  = 8'h39;
  localparam logic [7:0] CHAR_EQ = 8'h3D;

  // "<SOH>10=" as it appears in a left-shifting byte window, oldest byte in the MSBs
  localparam logic [31:0] TRAILER_TAG = {SOH, CHAR_1, CHAR_0, CHAR_EQ};

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_DIGITS,
    ST_TERM,
    ST_WAIT_CALC,
    ST_REPORT
  } fsm_state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISMATCH = 2'b01,
    ERR_FORMAT   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } chk_err_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHAR_0) && (b <= CHAR_9);
  endfunction

endpackage

// File: rtl/fix_tag_match.sv
// 4-byte shift window that flags a fixed tag; match is combinational on the byte being shifted in.
// Latency 0 (match in the accepting cycle); no backpressure, shift is gated by the caller.
module fix_tag_match #(
  parameter logic [31:0] PATTERN = 32'h0131_303D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       shift,
  input  logic       clear,
  output logic       match
);

  logic [31:0] window;
  logic [31:0] window_next;

  assign window_next = {window[23:0], data};

  // Looking at the post-shift window lets the caller move on in the same cycle the last tag byte lands.
  assign match = shift && (window_next == PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (clear) begin
      window <= '0;
    end else if (shift) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/fix_checksum_verify.sv
// Parses the FIX "10=ddd<SOH>" trailer and checks it against the computed checksum, one verdict per message.
// done_o 2 cycles after the trailer SOH when calc is available; valid_i gaps stall parsing, no backpressure.
module fix_checksum_verify
  import fix_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic [8:0] calc_checksum_i,
  input  logic       calc_valid_i,
  output logic       done_o,
  output logic       ok_o,
  output logic [1:0] err_o,
  output logic [7:0] rx_checksum_o
);

  fsm_state_t      state;
  logic [9:0]      acc;
  logic [1:0]      dcnt;
  logic            fmt_err;
  logic [TO_W-1:0] to_cnt;

  logic [8:0]      calc_q;
  logic            calc_seen;

  logic            hunt_shift;
  logic            win_clear;
  logic            tag_hit;
  logic [7:0]      digit;
  logic [9:0]      acc_next;
  logic            calc_avail;
  logic [8:0]      calc_use;
  logic            to_expired;
  chk_err_t        verdict;

  assign hunt_shift = valid_i && (state == ST_HUNT);
  assign win_clear  = (state == ST_REPORT);

  fix_tag_match #(
    .PATTERN(TRAILER_TAG)
  ) u_trailer_tag (
    .clk  (clk),
    .rst  (rst),
    .data (data_i),
    .shift(hunt_shift),
    .clear(win_clear),
    .match(tag_hit)
  );

  assign digit    = data_i - CHAR_0;
  assign acc_next = (acc * 10'd10) + {2'b00, digit};

  // A strobe in the deciding cycle is the newest value and takes precedence over the latch.
  assign calc_avail = calc_valid_i || calc_seen;
  assign calc_use   = calc_valid_i ? calc_checksum_i : calc_q;
  assign to_expired = (to_cnt == TO_W'(TIMEOUT));

  always_comb begin
    verdict = ERR_OK;
    if (fmt_err) begin
      verdict = ERR_FORMAT;
    end else if (!calc_avail) begin
      verdict = ERR_TIMEOUT;
    end else if ({1'b0, acc[7:0]} != calc_use) begin
      verdict = ERR_MISMATCH;
    end
  end

  // Calc latch is free-running; a strobe during REPORT survives the clear for the next message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_q    <= '0;
      calc_seen <= 1'b0;
    end else if (calc_valid_i) begin
      calc_q    <= calc_checksum_i;
      calc_seen <= 1'b1;
    end else if (state == ST_REPORT) begin
      calc_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_HUNT;
      acc           <= '0;
      dcnt          <= '0;
      fmt_err       <= 1'b0;
      to_cnt        <= '0;
      done_o        <= 1'b0;
      ok_o          <= 1'b0;
      err_o         <= ERR_OK;
      rx_checksum_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (tag_hit) begin
            state <= ST_DIGITS;
            acc   <= '0;
            dcnt  <= '0;
          end
        end

        ST_DIGITS: begin
          if (valid_i) begin
            if (is_digit(data_i)) begin
              acc  <= acc_next;
              dcnt <= dcnt + 2'd1;
              if (dcnt == 2'd2) begin
                state <= ST_TERM;
              end
            end else begin
              fmt_err <= 1'b1;
              state   <= ST_TERM;
            end
          end
        end

        ST_TERM: begin
          if (valid_i) begin
            if ((data_i != SOH) || (acc > 10'd255)) begin
              fmt_err <= 1'b1;
            end
            to_cnt <= '0;
            state  <= ST_WAIT_CALC;
          end
        end

        // Verdict is registered on the way into REPORT so done_o coincides with that state.
        ST_WAIT_CALC: begin
          if (fmt_err || calc_avail || to_expired) begin
            state         <= ST_REPORT;
            done_o        <= 1'b1;
            ok_o          <= (verdict == ERR_OK);
            err_o         <= verdict;
            rx_checksum_o <= acc[7:0];
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_REPORT: begin
          fmt_err <= 1'b0;
          to_cnt  <= '0;
          dcnt    <= '0;
          state   <= ST_HUNT;
        end

        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_checksum_verify.sv
// Directed bench for fix_checksum_verify: scoreboard of expected verdicts, checked when done_o fires.
module tb_fix_checksum_verify;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic [8:0] calc_checksum_i = 9'h000;
  logic       calc_valid_i = 1'b0;
  logic       done_o;
  logic       ok_o;
  logic [1:0] err_o;
  logic [7:0] rx_checksum_o;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic       ok;
    logic [1:0] err;
    logic [7:0] rx;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  fix_checksum_verify #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .calc_checksum_i(calc_checksum_i),
    .calc_valid_i   (calc_valid_i),
    .done_o         (done_o),
    .ok_o           (ok_o),
    .err_o          (err_o),
    .rx_checksum_o  (rx_checksum_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // '|' stands for SOH; returns the cycle in which the last byte was presented
  task automatic send_str(input string s, input bit gaps, output int last);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) idle($urandom_range(0, 2));
      data_i  = (s[i] == 8'h7C) ? 8'h01 : s[i];
      valid_i = 1'b1;
      last    = cyc;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic pulse_calc(input logic [8:0] v);
    calc_checksum_i = v;
    calc_valid_i    = 1'b1;
    @(posedge clk);
    #1;
    calc_valid_i = 1'b0;
  endtask

  task automatic expect_v(input logic ok, input logic [1:0] err, input logic [7:0] rx, input int c);
    exp_t e;
    e.ok  = ok;
    e.err = err;
    e.rx  = rx;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'd0, done_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ok", {31'd0, ok_o}, {31'd0, e.ok});
          check("err", {30'd0, err_o}, {30'd0, e.err});
          check("rx", {24'd0, rx_checksum_o}, {24'd0, e.rx});
          if (e.cyc >= 0) check("latency", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    #12;
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_ok", {31'd0, ok_o}, 32'd0);
    check("rst_err", {30'd0, err_o}, 32'd0);
    check("rst_rx", {24'd0, rx_checksum_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // calc latched ahead of the trailer
    send_str("8=FIX|35=A|", 1'b0, n);
    pulse_calc(9'd62);
    idle(2);
    send_str("10=062|", 1'b0, n);
    expect_v(1'b1, 2'b00, 8'h3E, n + 2);
    idle(4);

    // latest strobe wins: 62 then 63 -> mismatch
    pulse_calc(9'd62);
    pulse_calc(9'd63);
    send_str("35=0|10=062|", 1'b0, n);
    expect_v(1'b0, 2'b01, 8'h3E, n + 2);
    idle(4);

    // calc bit 8 set is always a mismatch
    pulse_calc(9'h13E);
    send_str("35=0|10=062|", 1'b0, n);
    expect_v(1'b0, 2'b01, 8'h3E, n + 2);
    idle(4);

    // non-digit in the digits: format error without any calc
    send_str("35=0|10=2a5", 1'b0, n);
    expect_v(1'b0, 2'b10, 8'h02, n + 2);
    send_str("|", 1'b0, n);
    idle(4);

    // value above 255
    send_str("35=0|10=300|", 1'b0, n);
    expect_v(1'b0, 2'b10, 8'h2C, n + 2);
    idle(4);

    // wrong terminator
    send_str("35=0|10=062X", 1'b0, n);
    expect_v(1'b0, 2'b10, 8'h3E, n + 2);
    send_str("|", 1'b0, n);
    idle(4);

    // no calc at all: timeout
    send_str("35=0|10=062|", 1'b0, n);
    expect_v(1'b0, 2'b11, 8'h3E, n + 1 + TIMEOUT + 1);
    idle(TIMEOUT + 6);

    // calc arrives 5 cycles after the SOH
    send_str("35=0|10=062|", 1'b0, n);
    expect_v(1'b1, 2'b00, 8'h3E, n + 6);
    idle(4);
    pulse_calc(9'd62);
    idle(4);

    // random valid gaps, and an embedded "210=" that must not trigger
    pulse_calc(9'd199);
    send_str("35=0|210=7|10=199|", 1'b1, n);
    expect_v(1'b1, 2'b00, 8'hC7, n + 2);
    idle(4);

    // strobe during REPORT is kept for the following message
    pulse_calc(9'd62);
    send_str("35=0|10=062|", 1'b0, n);
    expect_v(1'b1, 2'b00, 8'h3E, n + 2);
    idle(1);
    pulse_calc(9'd100);
    idle(2);
    send_str("35=0|10=100|", 1'b0, n);
    expect_v(1'b1, 2'b00, 8'h64, n + 2);
    idle(4);

    // strobe in the same cycle as the trailer SOH
    send_str("35=0|10=077", 1'b0, n);
    data_i          = 8'h01;
    valid_i         = 1'b1;
    calc_checksum_i = 9'd77;
    calc_valid_i    = 1'b1;
    n               = cyc;
    expect_v(1'b1, 2'b00, 8'h4D, n + 2);
    @(posedge clk);
    #1;
    valid_i      = 1'b0;
    calc_valid_i = 1'b0;
    idle(4);

    // reset mid-trailer drops everything
    pulse_calc(9'd62);
    send_str("35=0|10=06", 1'b0, n);
    rst = 1'b1;
    #1;
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_ok", {31'd0, ok_o}, 32'd0);
    check("midrst_err", {30'd0, err_o}, 32'd0);
    check("midrst_rx", {24'd0, rx_checksum_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send_str("2|", 1'b0, n);
    idle(4);

    pulse_calc(9'd62);
    send_str("35=0|10=062|", 1'b0, n);
    expect_v(1'b1, 2'b00, 8'h3E, n + 2);

    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    idle(TIMEOUT + 4);
    check("drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
